// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared encodings for the stage-1 fetch sequencer: PC mux selects,
// FSM state type and the word-alignment helper applied to redirect targets.
package pc_fetch_ctrl_pkg;

    localparam logic PC_SEL_PC_4 = 1'b0;
    localparam logic PC_SEL_ALU  = 1'b1;

    localparam int KILL_W = 2;

    typedef enum logic [1:0] {
        FETCH_BOOT  = 2'd0,
        FETCH_RUN   = 2'd1,
        FETCH_STALL = 2'd2
    } fetch_state_t;

    // Instruction fetches are word aligned; drop the byte-offset bits.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_fetch_ctrl_redirect_buf.sv
// Single-entry redirect buffer: holds the most recent branch target that
// arrived while the I-cache was stalled, until the stall drains.
module pc_redirect_buf
    import pc_fetch_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] load_target,
    input  logic        consume,
    output logic        valid,
    output logic [31:0] target
);

    // Valid flag: set on load (newest wins), cleared when the stall drains.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
        end else if (consume) begin
            valid <= 1'b0;
        end
    end

    // Target payload: only meaningful while valid, so it needs no reset.
    always_ff @(posedge clk) begin
        if (load) begin
            target <= align_word(load_target);
        end
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Stage-1 fetch sequencer: owns the PC register, drives the PC mux select,
// issues I-cache reads, holds across stalls and kills wrong-path slots.
module pc_fetch_ctrl
    import pc_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_2000,
    parameter int          KILL_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        icache_stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] pc_fetch,
    output logic [31:0] pc_4,
    output logic        pc_sel,
    output logic        icache_re,
    output logic        inst_kill
);

    fetch_state_t        state;
    logic [KILL_W-1:0]   kill_cnt;
    logic                pend_valid;
    logic [31:0]         pend_target;
    logic                take_redirect;
    logic [31:0]         redirect_pc;
    logic                buf_load;
    logic                buf_consume;

    localparam logic [KILL_W-1:0] KILL_LOAD = KILL_W'(KILL_CYCLES);

    // A redirect is applied in a cycle the PC actually advances: live
    // redirect in unstalled RUN, or stall release with a live or buffered one.
    always_comb begin
        take_redirect = 1'b0;
        case (state)
            FETCH_RUN:   take_redirect = redirect_valid && !icache_stall;
            FETCH_STALL: take_redirect = !icache_stall && (redirect_valid || pend_valid);
            default:     take_redirect = 1'b0;
        endcase
    end

    // Live redirect beats the buffered one when both are present.
    assign redirect_pc = redirect_valid ? align_word(redirect_target) : pend_target;

    assign pc_sel    = take_redirect ? PC_SEL_ALU : PC_SEL_PC_4;
    assign pc_4      = pc_fetch + 32'd4;
    assign icache_re = (state != FETCH_BOOT);
    assign inst_kill = (kill_cnt != '0) || (state == FETCH_BOOT);

    assign buf_load    = icache_stall && redirect_valid &&
                         (state == FETCH_RUN || state == FETCH_STALL);
    assign buf_consume = (state == FETCH_STALL) && !icache_stall;

    pc_redirect_buf u_redirect_buf (
        .clk         (clk),
        .reset       (reset),
        .load        (buf_load),
        .load_target (redirect_target),
        .consume     (buf_consume),
        .valid       (pend_valid),
        .target      (pend_target)
    );

    // Fetch FSM and PC register: advance or redirect on unstalled cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= FETCH_BOOT;
            pc_fetch <= RESET_PC;
        end else begin
            case (state)
                FETCH_BOOT: begin
                    state <= FETCH_RUN;
                end
                FETCH_RUN: begin
                    if (icache_stall) begin
                        state <= FETCH_STALL;
                    end else begin
                        pc_fetch <= take_redirect ? redirect_pc : pc_4;
                    end
                end
                FETCH_STALL: begin
                    if (!icache_stall) begin
                        state    <= FETCH_RUN;
                        pc_fetch <= take_redirect ? redirect_pc : pc_4;
                    end
                end
                default: begin
                    state <= FETCH_BOOT;
                end
            endcase
        end
    end

    // Wrong-path kill counter: reloaded per redirect, counts down on
    // unstalled cycles and saturates at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            kill_cnt <= '0;
        end else if (take_redirect) begin
            kill_cnt <= KILL_LOAD;
        end else if (!icache_stall && kill_cnt != '0) begin
            kill_cnt <= kill_cnt - 1'b1;
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Scoreboard bench for pc_fetch_ctrl: a driver applies one input vector per
// cycle and queues the hand-computed outputs; a monitor pops and compares.
module tb_pc_fetch_ctrl;

    logic        clk;
    logic        reset;
    logic        icache_stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] pc_fetch;
    logic [31:0] pc_4;
    logic        pc_sel;
    logic        icache_re;
    logic        inst_kill;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        re;
        logic        kill;
        logic        sel;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    int   n_step = 0;

    pc_fetch_ctrl #(
        .RESET_PC    (32'h0000_2000),
        .KILL_CYCLES (1)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .icache_stall    (icache_stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .pc_fetch        (pc_fetch),
        .pc_4            (pc_4),
        .pc_sel          (pc_sel),
        .icache_re       (icache_re),
        .inst_kill       (inst_kill)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called just after a rising edge: apply this cycle's inputs, queue the
    // outputs expected during this cycle, then advance one clock.
    task automatic step(input logic rst, input logic stall, input logic rv,
                        input logic [31:0] tgt, input logic [31:0] e_pc,
                        input logic e_re, input logic e_kill, input logic e_sel);
        exp_t e;
        reset           = rst;
        icache_stall    = stall;
        redirect_valid  = rv;
        redirect_target = tgt;
        e.pc   = e_pc;
        e.pc4  = e_pc + 32'd4;
        e.re   = e_re;
        e.kill = e_kill;
        e.sel  = e_sel;
        exp_q.push_back(e);
        n_step++;
        @(posedge clk);
        #1;
    endtask

    // Monitor: outputs are presented every cycle; compare mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_vec++;
            if (pc_fetch !== e.pc) begin
                n_miss++;
                $display("FAIL pc_fetch step %0d: got %h want %h", n_vec, pc_fetch, e.pc);
            end
            n_vec++;
            if (pc_4 !== e.pc4) begin
                n_miss++;
                $display("FAIL pc_4 step %0d: got %h want %h", n_vec, pc_4, e.pc4);
            end
            n_vec++;
            if (icache_re !== e.re) begin
                n_miss++;
                $display("FAIL icache_re step %0d: got %b want %b", n_vec, icache_re, e.re);
            end
            n_vec++;
            if (inst_kill !== e.kill) begin
                n_miss++;
                $display("FAIL inst_kill step %0d: got %b want %b", n_vec, inst_kill, e.kill);
            end
            n_vec++;
            if (pc_sel !== e.sel) begin
                n_miss++;
                $display("FAIL pc_sel step %0d: got %b want %b", n_vec, pc_sel, e.sel);
            end
        end
    end

    initial begin
        reset           = 1'b1;
        icache_stall    = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        @(posedge clk);
        #1;

        // Reset held three cycles, BOOT one cycle, then sequential fetch.
        step(1, 0, 0, 32'h0,         32'h0000_2000, 0, 1, 0);
        step(1, 0, 0, 32'h0,         32'h0000_2000, 0, 1, 0);
        step(0, 0, 0, 32'h0,         32'h0000_2000, 0, 1, 0);
        step(0, 0, 0, 32'h0,         32'h0000_2000, 1, 0, 0);
        step(0, 0, 0, 32'h0,         32'h0000_2004, 1, 0, 0);
        // Redirect to 0x3000 at 0x2008: one killed slot then 0x3004.
        step(0, 0, 1, 32'h0000_3000, 32'h0000_2008, 1, 0, 1);
        step(0, 0, 0, 32'h0,         32'h0000_3000, 1, 1, 0);
        step(0, 0, 1, 32'h0000_2010, 32'h0000_3004, 1, 0, 1);
        // Four-cycle stall at 0x2010 with a redirect to 0x4002 mid-stall.
        step(0, 1, 0, 32'h0,         32'h0000_2010, 1, 1, 0);
        step(0, 1, 1, 32'h0000_4002, 32'h0000_2010, 1, 1, 0);
        step(0, 1, 0, 32'h0,         32'h0000_2010, 1, 1, 0);
        step(0, 1, 0, 32'h0,         32'h0000_2010, 1, 1, 0);
        step(0, 0, 0, 32'h0,         32'h0000_2010, 1, 1, 1);
        // Pending 0x4000, then a live 0x5000 on the stall-release cycle wins.
        step(0, 1, 1, 32'h0000_4000, 32'h0000_4000, 1, 1, 0);
        step(0, 0, 1, 32'h0000_5000, 32'h0000_4000, 1, 1, 1);
        step(0, 0, 0, 32'h0,         32'h0000_5000, 1, 1, 0);
        // Pending must be empty: a plain stall releases to pc+4.
        step(0, 1, 0, 32'h0,         32'h0000_5004, 1, 0, 0);
        step(0, 0, 0, 32'h0,         32'h0000_5004, 1, 0, 0);
        // Wrap of the PC at the top of the address space.
        step(0, 0, 1, 32'hFFFF_FFFC, 32'h0000_5008, 1, 0, 1);
        step(0, 0, 0, 32'h0,         32'hFFFF_FFFC, 1, 1, 0);
        // Unaligned live redirect target is forced to a word boundary.
        step(0, 0, 1, 32'h0000_6003, 32'h0000_0000, 1, 0, 1);
        // Reset in STALL with a pending redirect: BOOT, pending dropped.
        step(0, 1, 1, 32'h0000_7000, 32'h0000_6000, 1, 1, 0);
        step(1, 1, 0, 32'h0,         32'h0000_6000, 1, 1, 0);
        step(0, 0, 0, 32'h0,         32'h0000_2000, 0, 1, 0);
        step(0, 1, 0, 32'h0,         32'h0000_2000, 1, 0, 0);
        step(0, 0, 0, 32'h0,         32'h0000_2000, 1, 0, 0);
        step(0, 0, 0, 32'h0,         32'h0000_2004, 1, 0, 0);

        // Let the monitor drain, bounded by a few cycles.
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) begin
            @(posedge clk);
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL drain: got %0d entries left want 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
